// File: rtl/add_seq_ctrl_if.sv
// Requester, consumer and shared-adder signals of the byte-serial add/sub sequencer.
interface add_seq_ctrl_if #(
  parameter int unsigned BYTES = 4
);
  localparam int unsigned W = 8 * BYTES;

  logic         in_valid;
  logic         in_ready;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic [7:0]   adder_x;
  logic [7:0]   adder_y;
  logic         adder_cin;
  logic [7:0]   adder_sum;
  logic         adder_cout;

  // Sequencer side
  modport slave (
    input  in_valid, op, a, b, cin, out_ready, adder_sum, adder_cout,
    output in_ready, out_valid, result, cout, ovf, adder_x, adder_y, adder_cin
  );

  // Requester / consumer / adder side
  modport master (
    output in_valid, op, a, b, cin, out_ready, adder_sum, adder_cout,
    input  in_ready, out_valid, result, cout, ovf, adder_x, adder_y, adder_cin
  );
endinterface

// File: rtl/add_seq_ctrl.sv
// Byte-serial sequencer: walks an external 8-bit adder LSB-first to add or
// subtract BYTES-wide operands, returning result, carry-out and signed overflow.
module add_seq_ctrl #(
  parameter int unsigned BYTES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  add_seq_ctrl_if.slave io
);

  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned LAST  = BYTES - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  logic [BYTES-1:0][7:0]   r_a;
  logic [BYTES-1:0][7:0]   r_b;
  logic [BYTES-1:0][7:0]   r_result;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_carry;
  logic                    r_cout;
  logic                    r_ovf;

  logic                    w_run;
  logic                    w_last;

  assign w_run  = rst_n && (r_state == S_RUN);
  assign w_last = (r_idx == IDX_W'(LAST));

  // Subtract is a + ~b + 1, so B is stored inverted and the carry seeded with 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io.in_valid) begin
            r_a      <= io.a;
            r_b      <= io.op ? ~io.b : io.b;
            r_carry  <= io.op ? 1'b1 : io.cin;
            r_idx    <= '0;
            r_result <= '0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_result[r_idx] <= io.adder_sum;
          r_carry         <= io.adder_cout;
          if (w_last) begin
            r_cout  <= io.adder_cout;
            r_ovf   <= (r_a[LAST][7] == r_b[LAST][7]) &&
                       (io.adder_sum[7] != r_a[LAST][7]);
            r_idx   <= '0;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_DONE: begin
          if (io.out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Handshake flags are also qualified by rst_n so nothing is offered while reset is held.
  assign io.in_ready  = rst_n && (r_state == S_IDLE);
  assign io.out_valid = rst_n && (r_state == S_DONE);
  assign io.result    = r_result;
  assign io.cout      = r_cout;
  assign io.ovf       = r_ovf;

  assign io.adder_x   = w_run ? r_a[r_idx] : 8'h00;
  assign io.adder_y   = w_run ? r_b[r_idx] : 8'h00;
  assign io.adder_cin = w_run ? r_carry    : 1'b0;

endmodule

// File: doc/add_seq_ctrl.md
# add_seq_ctrl

Byte-serial sequencer that drives the team's shared 8-bit combinational adder to perform BYTES-wide add or subtract operations, LSB byte first. Carry is registered between bytes. The block sits between a requester and the adder. It accepts an operand pair over a valid/ready handshake, walks the adder across BYTES cycles and returns the full-width result, carry-out and signed overflow over a second valid/ready handshake.

## Interface
- BYTES, 4: operand width in bytes; legal range 2..16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- in_valid  input  1  requester presents an operation.
- in_ready  output  1  block can accept; high only in IDLE with rst_n high.
- op  input  1  0 = add (a + b + cin), 1 = subtract (a - b); cin is ignored when op=1.
- a  input  8*BYTES  operand A.
- b  input  8*BYTES  operand B.
- cin  input  1  carry-in for add.
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  consumer accepts result.
- result  output  8*BYTES  sum or difference.
- cout  output  1  final carry; for subtract, 1 = no borrow.
- ovf  output  1  two's-complement overflow.
- adder_x  output  8  adder operand X byte.
- adder_y  output  8  adder operand Y byte.
- adder_cin  output  1  adder carry-in.
- adder_sum  input  8  adder sum, combinational from adder_x/adder_y/adder_cin.
- adder_cout  input  1  adder carry-out, combinational.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch a, and either b (op=0) or ~b (op=1);
  - set carry register to cin (op=0) or 1 (op=1);
  - set idx to 0, clear result;
  - go to RUN.
- RUN: drive adder_x = A[idx], adder_y = B'[idx], adder_cin = carry register.
  - At each edge: result[idx] <= adder_sum; carry <= adder_cout; idx <= idx+1.
  - At idx == BYTES-1: also set cout <= adder_cout and ovf <= (A_msb == B'_msb) && (adder_sum[7] != A_msb), then go to DONE.
- DONE: out_valid=1. result, cout and ovf are held stable. On out_ready, go to IDLE.
- Outside RUN, adder_x, adder_y and adder_cin are driven 0.
- idx width is ceil(log2(BYTES)); it never exceeds BYTES-1.
- in_valid is ignored outside IDLE. Latched operands are unaffected by input changes after acceptance.
- result, cout and ovf keep their last values in IDLE until the next acceptance clears result.

## Timing
- Reset (rst_n low at an edge), regardless of state:
  - state goes to IDLE; result=0, cout=0, ovf=0, idx=0, carry=0;
  - out_valid=0 and adder outputs=0;
  - in_ready=0 while rst_n is low, and 1 from the first cycle rst_n is high.
- Reset mid-RUN or mid-DONE aborts the operation; no partial result is presented.
- Latency: operation accepted at edge E0; RUN occupies the BYTES cycles after E0; out_valid rises after edge E0+BYTES.
- Minimum issue interval is BYTES+2 cycles: accept, BYTES run cycles, DONE for at least 1 cycle, then back to IDLE.
- out_valid&&out_ready at edge E moves the FSM to IDLE. in_ready goes high after E; there is no same-cycle accept.
- The adder path is combinational in one cycle: adder_outputs -> adder_sum/cout -> registers.

## Test plan
- Reset: hold rst_n low 3 cycles mid-traffic.
  - Required: all outputs 0, in_ready=0 during reset, in_ready=1 the cycle after release.
- Add 0xFFFFFFFF + 0x00000001, cin=0.
  - Required per RUN cycle: adder_x = FF, FF, FF, FF; adder_y = 01, 00, 00, 00; adder_cin = 0, 1, 1, 1.
  - Required result: out_valid 4 cycles after accept, result=0x00000000, cout=1, ovf=0.
- Add 0x7FFFFFFF + 0x00000001, cin=0.
  - Required: result=0x80000000, cout=0, ovf=1.
- Subtract 0x00000005 - 0x00000007 (cin driven 1, ignored).
  - Required: result=0xFFFFFFFE, cout=0, ovf=0.
- Subtract 0x80000000 - 0x00000001.
  - Required: result=0x7FFFFFFF, cout=1, ovf=1.
- Backpressure: hold out_ready low 5 cycles while toggling in_valid and the a/b inputs.
  - Required: result, cout and ovf stable; in_ready=0; no new acceptance.
  - Release out_ready; the next op (0x12345678 + 0x11111111) yields 0x23456789.
- Reset asserted in the 2nd RUN cycle.
  - Required: IDLE on the next cycle, out_valid never rises for the aborted op, and the following add 0x000000FF + 0x00000001 gives 0x00000100.
